// File: rtl/noc_pe_interface.sv
// PE-side network interface: packetizes core commands into header+payload flits toward the
// router and reframes incoming router flits (sop/eop/err) for the core.
module noc_pe_interface #(
   parameter int n       = 32,
   parameter int COORD_W = 4,
   parameter int SRCX    = 0,
   parameter int SRCY    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_cmd_valid,
   output logic                          tx_cmd_ready,
   input  logic [COORD_W-1:0]            tx_dst_x,
   input  logic [COORD_W-1:0]            tx_dst_y,
   input  logic [n-4*COORD_W-1:0]        tx_len,
   input  logic                          tx_data_valid,
   output logic                          tx_data_ready,
   input  logic [n-1:0]                  tx_data,
   output logic                          net_out_req,
   input  logic                          net_out_ack,
   output logic [n-1:0]                  net_out_data,
   input  logic                          net_in_req,
   output logic                          net_in_ack,
   input  logic [n-1:0]                  net_in_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [n-1:0]                  rx_data,
   output logic                          rx_sop,
   output logic                          rx_eop,
   output logic                          rx_err
);

   localparam int LEN_W = n - 4*COORD_W;
   localparam logic [COORD_W-1:0] SRC_X = COORD_W'(SRCX);
   localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(SRCY);

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_HDR  = 2'd1;
   localparam logic [1:0] T_BODY = 2'd2;

   localparam logic [0:0] R_HDR  = 1'b0;
   localparam logic [0:0] R_BODY = 1'b1;

   logic [1:0]       tx_state;
   logic             run;
   logic [LEN_W-1:0] tx_cnt;
   logic [LEN_W-1:0] ld_left;
   logic             tx_fire;
   logic             tx_load;

   logic [0:0]       rx_state;
   logic [LEN_W-1:0] rx_cnt;
   logic             rx_take;
   logic [LEN_W-1:0] in_len;

   // run keeps tx_cmd_ready low through reset and rises the cycle after release
   assign tx_cmd_ready  = run && (tx_state == T_IDLE);
   assign tx_fire       = net_out_req && net_out_ack;
   assign tx_data_ready = run && (tx_state != T_IDLE) && (ld_left != '0) &&
                          (!net_out_req || net_out_ack);
   assign tx_load       = tx_data_valid && tx_data_ready;

   // NOTE: state registers use non-blocking assignments so every always_ff reads pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state     <= T_IDLE;
         run          <= 1'b0;
         tx_cnt       <= '0;
         ld_left      <= '0;
         net_out_req  <= 1'b0;
         net_out_data <= '0;
      end else begin
         run <= 1'b1;
         case (tx_state)
            T_IDLE: begin
               if (tx_cmd_valid && tx_cmd_ready) begin
                  net_out_data <= {tx_dst_x, tx_dst_y, SRC_X, SRC_Y, tx_len};
                  net_out_req  <= 1'b1;
                  tx_cnt       <= tx_len;
                  ld_left      <= tx_len;
                  tx_state     <= T_HDR;
               end
            end
            T_HDR, T_BODY: begin
               if (tx_load) begin
                  net_out_data <= tx_data;
                  net_out_req  <= 1'b1;
                  ld_left      <= ld_left - LEN_W'(1);
               end else if (tx_fire) begin
                  net_out_req <= 1'b0;
               end
               // in T_HDR tx_cnt still holds len; in T_BODY it counts unacked payload flits
               if (tx_fire) begin
                  if (tx_state == T_HDR) begin
                     tx_state <= (tx_cnt == '0) ? T_IDLE : T_BODY;
                  end else begin
                     tx_cnt <= tx_cnt - LEN_W'(1);
                     if (tx_cnt == LEN_W'(1)) tx_state <= T_IDLE;
                  end
               end
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end

   assign net_in_ack = !rx_valid || rx_ready;
   assign rx_take    = net_in_req && net_in_ack;
   assign in_len     = net_in_data[LEN_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state <= R_HDR;
         rx_cnt   <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_sop   <= 1'b0;
         rx_eop   <= 1'b0;
         rx_err   <= 1'b0;
      end else if (rx_take) begin
         rx_valid <= 1'b1;
         rx_data  <= net_in_data;
         if (rx_state == R_HDR) begin
            rx_sop <= 1'b1;
            rx_err <= (net_in_data[n-1 -: 2*COORD_W] != {SRC_X, SRC_Y});
            rx_eop <= (in_len == '0);
            rx_cnt <= in_len;
            if (in_len != '0) rx_state <= R_BODY;
         end else begin
            // misrouted packets still stream through; rx_err stays as the header set it
            rx_sop <= 1'b0;
            rx_eop <= (rx_cnt == LEN_W'(1));
            rx_cnt <= rx_cnt - LEN_W'(1);
            if (rx_cnt == LEN_W'(1)) rx_state <= R_HDR;
         end
      end else if (rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench: instance a sits at node (0,1) for TX checks, instance b at node (1,1) for RX
// checks; both share all inputs.
module tb_noc_pe_interface;

   logic        clk;
   logic        rst;
   logic        tx_cmd_valid;
   logic [3:0]  tx_dst_x, tx_dst_y;
   logic [15:0] tx_len;
   logic        tx_data_valid;
   logic [31:0] tx_data;
   logic        net_out_ack;
   logic        net_in_req;
   logic [31:0] net_in_data;
   logic        rx_ready;

   logic        tx_cmd_ready_a, tx_data_ready_a, net_out_req_a, net_in_ack_a;
   logic [31:0] net_out_data_a, rx_data_a;
   logic        rx_valid_a, rx_sop_a, rx_eop_a, rx_err_a;
   logic        tx_cmd_ready_b, tx_data_ready_b, net_out_req_b, net_in_ack_b;
   logic [31:0] net_out_data_b, rx_data_b;
   logic        rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] flits[$];
   logic [34:0] expv[$];
   logic [34:0] got[$];

   noc_pe_interface #(.n(32), .COORD_W(4), .SRCX(0), .SRCY(1)) dut_a (
      .clk(clk), .rst(rst),
      .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready_a),
      .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_len(tx_len),
      .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready_a), .tx_data(tx_data),
      .net_out_req(net_out_req_a), .net_out_ack(net_out_ack), .net_out_data(net_out_data_a),
      .net_in_req(net_in_req), .net_in_ack(net_in_ack_a), .net_in_data(net_in_data),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready), .rx_data(rx_data_a),
      .rx_sop(rx_sop_a), .rx_eop(rx_eop_a), .rx_err(rx_err_a)
   );

   noc_pe_interface #(.n(32), .COORD_W(4), .SRCX(1), .SRCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready_b),
      .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_len(tx_len),
      .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready_b), .tx_data(tx_data),
      .net_out_req(net_out_req_b), .net_out_ack(net_out_ack), .net_out_data(net_out_data_b),
      .net_in_req(net_in_req), .net_in_ack(net_in_ack_b), .net_in_data(net_in_data),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready), .rx_data(rx_data_b),
      .rx_sop(rx_sop_b), .rx_eop(rx_eop_b), .rx_err(rx_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] flags_a();
      return {tx_cmd_ready_a, tx_data_ready_a, net_out_req_a, rx_valid_a, rx_sop_a, rx_eop_a, rx_err_a};
   endfunction

   function automatic logic [6:0] flags_b();
      return {tx_cmd_ready_b, tx_data_ready_b, net_out_req_b, rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b};
   endfunction

   // Streams flits into both instances honouring net_in_ack_b; collects what dut_b hands the core.
   task automatic rx_run(input string tag, input logic [31:0] pat);
      int  idx = 0;
      int  cyc = 0;
      bit  fire;
      got.delete();
      net_in_req  = (flits.size() > 0);
      net_in_data = flits[0];
      rx_ready    = pat[0];
      while ((idx < flits.size() || rx_valid_b) && cyc < 200) begin
         @(negedge clk);
         fire = net_in_req && net_in_ack_b;
         if (rx_valid_b && rx_ready) got.push_back({rx_err_b, rx_sop_b, rx_eop_b, rx_data_b});
         tick();
         if (fire) idx++;
         cyc++;
         net_in_req  = (idx < flits.size());
         net_in_data = (idx < flits.size()) ? flits[idx] : 32'h0;
         rx_ready    = pat[cyc % 32];
      end
      net_in_req = 1'b0;
      rx_ready   = 1'b1;
      check({tag, " timeout"}, 64'(cyc < 200), 64'd1);
      check({tag, " count"}, 64'(got.size()), 64'(expv.size()));
      for (int i = 0; i < expv.size() && i < got.size(); i++)
         check($sformatf("%s flit%0d {err,sop,eop,data}", tag, i), 64'(got[i]), 64'(expv[i]));
   endtask

   initial begin
      // reset with random inputs
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tx_cmd_valid  = 1'($urandom);
         tx_dst_x      = 4'($urandom);
         tx_dst_y      = 4'($urandom);
         tx_len        = 16'($urandom);
         tx_data_valid = 1'($urandom);
         tx_data       = $urandom;
         net_out_ack   = 1'($urandom);
         net_in_req    = 1'($urandom);
         net_in_data   = $urandom;
         rx_ready      = 1'($urandom);
         tick();
      end
      check("reset flags a", 64'(flags_a()), 64'd0);
      check("reset flags b", 64'(flags_b()), 64'd0);
      check("reset net_out_data", 64'(net_out_data_a), 64'd0);
      check("reset rx_data", 64'(rx_data_b), 64'd0);

      tx_cmd_valid = 0; tx_data_valid = 0; net_in_req = 0; net_out_ack = 0; rx_ready = 1;
      tx_dst_x = 0; tx_dst_y = 0; tx_len = 0; tx_data = 0; net_in_data = 0;
      rst = 1'b1;
      tick();
      check("cmd_ready after reset", 64'(tx_cmd_ready_a), 64'd1);

      // TX: dst (1,0) len 2, full-rate ack
      tx_cmd_valid = 1; tx_dst_x = 4'd1; tx_dst_y = 4'd0; tx_len = 16'd2;
      tx_data_valid = 1; tx_data = 32'hA; net_out_ack = 1;
      tick();
      check("tx hdr", 64'({net_out_req_a, net_out_data_a}), 64'h1_1001_0002);
      check("tx cmd_ready low", 64'(tx_cmd_ready_a), 64'd0);
      tx_cmd_valid = 0;
      tick();
      check("tx flit A", 64'({net_out_req_a, net_out_data_a}), 64'h1_0000_000A);
      tx_data = 32'hB;
      tick();
      check("tx flit B", 64'({net_out_req_a, net_out_data_a}), 64'h1_0000_000B);
      check("tx data_ready done", 64'(tx_data_ready_a), 64'd0);
      tx_data_valid = 0;
      tick();
      check("tx idle req", 64'(net_out_req_a), 64'd0);
      check("tx cmd_ready back", 64'(tx_cmd_ready_a), 64'd1);

      // TX backpressure: dst (2,3) len 3, ack held low on the first payload flit
      tx_cmd_valid = 1; tx_dst_x = 4'd2; tx_dst_y = 4'd3; tx_len = 16'd3;
      tx_data_valid = 1; tx_data = 32'h11;
      tick();
      check("bp hdr", 64'({net_out_req_a, net_out_data_a}), 64'h1_2301_0003);
      tx_cmd_valid = 0;
      tick();
      check("bp flit 11", 64'({net_out_req_a, net_out_data_a}), 64'h1_0000_0011);
      net_out_ack = 0; tx_data = 32'h22;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("bp hold %0d", c), 64'({tx_data_ready_a, net_out_req_a, net_out_data_a}),
               64'h1_0000_0011);
      end
      net_out_ack = 1;
      #1;
      check("bp data_ready on ack", 64'(tx_data_ready_a), 64'd1);
      tick();
      check("bp flit 22", 64'({net_out_req_a, net_out_data_a}), 64'h1_0000_0022);
      tx_data = 32'h33;
      tick();
      check("bp flit 33", 64'({tx_data_ready_a, net_out_req_a, net_out_data_a}), 64'h1_0000_0033);
      tx_data_valid = 0;
      tick();
      check("bp done", 64'({tx_cmd_ready_a, net_out_req_a}), 64'd2);

      // RX at node (1,1), core ready toggling
      flits = '{32'h1100_0003, 32'h1, 32'h2, 32'h3};
      expv  = '{{3'b010, 32'h1100_0003}, {3'b000, 32'h1}, {3'b000, 32'h2}, {3'b001, 32'h3}};
      rx_run("rx toggle", 32'h9C6B_35A5);

      // RX misroute (dst 0,0) followed by a correct zero-length packet
      flits = '{32'h0011_0000, 32'h1122_0000};
      expv  = '{{3'b111, 32'h0011_0000}, {3'b011, 32'h1122_0000}};
      rx_run("rx misroute", 32'hFFFF_FFFF);

      // Concurrency: TX len 4 and RX len 4 overlap, then reset mid-packet
      tx_cmd_valid = 1; tx_dst_x = 4'd1; tx_dst_y = 4'd1; tx_len = 16'd4;
      tx_data_valid = 1; tx_data = 32'h100; net_out_ack = 1;
      net_in_req = 1; net_in_data = 32'h1100_0004; rx_ready = 1;
      tick();
      check("cc tx hdr", 64'({net_out_req_a, net_out_data_a}), 64'h1_1101_0004);
      check("cc rx hdr", 64'({rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b, rx_data_b}), 64'hC_1100_0004);
      tx_cmd_valid = 0; net_in_data = 32'h201;
      tick();
      check("cc tx p0", 64'(net_out_data_a), 64'h100);
      check("cc rx p0", 64'({rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b, rx_data_b}), 64'h8_0000_0201);
      tx_data = 32'h101; net_in_data = 32'h202;
      tick();
      rst = 1'b0;
      tick();
      check("cc reset flags a", 64'(flags_a()), 64'd0);
      check("cc reset flags b", 64'(flags_b()), 64'd0);
      check("cc reset data", 64'({net_out_data_a, rx_data_b}), 64'd0);
      rst = 1'b1; net_in_req = 0; tx_data_valid = 0;
      tick();
      check("cc cmd_ready", 64'(tx_cmd_ready_a), 64'd1);

      tx_cmd_valid = 1; tx_dst_x = 4'd3; tx_dst_y = 4'd2; tx_len = 16'd1;
      tx_data_valid = 1; tx_data = 32'h55;
      net_in_req = 1; net_in_data = 32'h1100_0001;
      tick();
      check("cc2 tx hdr", 64'({net_out_req_a, net_out_data_a}), 64'h1_3201_0001);
      check("cc2 rx hdr", 64'({rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b, rx_data_b}), 64'hC_1100_0001);
      tx_cmd_valid = 0; net_in_data = 32'h66;
      tick();
      check("cc2 tx p0", 64'({tx_data_ready_a, net_out_req_a, net_out_data_a}), 64'h1_0000_0055);
      check("cc2 rx p0", 64'({rx_valid_b, rx_sop_b, rx_eop_b, rx_err_b, rx_data_b}), 64'hA_0000_0066);
      net_in_req = 0; tx_data_valid = 0;
      tick();
      check("cc2 tx idle", 64'({tx_cmd_ready_a, net_out_req_a}), 64'd2);
      check("cc2 rx drained", 64'(rx_valid_b), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
